// File: rtl/sram_arb_pkg.sv
// Shared types for the two-master SRAM-like port arbiter: FSM states,
// owner encoding and transfer-size codes.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  function automatic logic size_legal(logic [1:0] size);
    return (size == SZ_BYTE) || (size == SZ_HALF) || (size == SZ_WORD);
  endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// Priority decision between fetch and data, with the counter that bounds how
// many data grants may pass a waiting fetch.
module sram_arb_pick
  import sram_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic inst_req,
  input  logic data_req,
  input  logic grant_en,
  output logic grant_owner
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic          starved;
  logic          pick_data;

  assign starved     = (starve_cnt_q == LIMIT);
  // Data wins unless fetch has already been passed over LIMIT times in a row.
  assign pick_data   = data_req && !(inst_req && starved);
  assign grant_owner = pick_data ? OWN_DATA : OWN_INST;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant_en) begin
      if (pick_data && inst_req) begin
        starve_cnt_d = starved ? LIMIT : starve_cnt_q + CW'(1);
      end else begin
        starve_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and data access,
// one transaction at a time, routing each response back to its owner.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              protocol_err
);

  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  logic   protocol_err_q;
  logic   grant_en;
  logic   grant_owner;

  assign grant_en = (state_q == IDLE) && (inst_req || data_req);
  assign owner_d  = grant_en ? owner_e'(grant_owner) : owner_q;

  sram_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .clk        (clk),
    .resetn     (resetn),
    .inst_req   (inst_req),
    .data_req   (data_req),
    .grant_en   (grant_en),
    .grant_owner(grant_owner)
  );

  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    mem_size     = '0;
    mem_addr     = '0;
    mem_wdata    = '0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    inst_rdata   = '0;
    data_rdata   = '0;
    case (state_q)
      IDLE: begin
        if (grant_en) state_d = REQ;
      end
      REQ: begin
        mem_req = 1'b1;
        if (owner_q == OWN_DATA) begin
          mem_wr       = data_wr;
          mem_size     = data_size;
          mem_addr     = data_addr;
          mem_wdata    = data_wdata;
          data_addr_ok = mem_addr_ok;
        end else begin
          mem_wr       = inst_wr;
          mem_size     = inst_size;
          mem_addr     = inst_addr;
          mem_wdata    = inst_wdata;
          inst_addr_ok = mem_addr_ok;
        end
        if (mem_addr_ok) state_d = RESP;
      end
      RESP: begin
        if (mem_data_ok) begin
          state_d = IDLE;
          if (owner_q == OWN_DATA) begin
            data_data_ok = 1'b1;
            data_rdata   = mem_rdata;
          end else begin
            inst_data_ok = 1'b1;
            inst_rdata   = mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // protocol_err is registered so it can never glitch high while in reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= IDLE;
      owner_q        <= OWN_INST;
      protocol_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      protocol_err_q <= mem_data_ok && (state_q != RESP);
    end
  end

  assign busy         = (state_q != IDLE);
  assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios plus a
// randomized run checked against a transaction-level arbitration model.
module tb_sram_port_arbiter;
  import sram_arb_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          inst_req, inst_wr, data_req, data_wr;
  logic [1:0]    inst_size, data_size;
  logic [AW-1:0] inst_addr, data_addr;
  logic [DW-1:0] inst_wdata, data_wdata;
  logic          inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [DW-1:0] inst_rdata, data_rdata;
  logic          mem_req, mem_wr;
  logic [1:0]    mem_size;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_addr_ok, mem_data_ok;
  logic [DW-1:0] mem_rdata;
  logic          busy, protocol_err;

  logic [137:0]  all_out;
  assign all_out = {inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok,
                    data_rdata, mem_req, mem_wr, mem_size, mem_addr, mem_wdata, busy,
                    protocol_err};

  int checks = 0;
  int passed = 0;
  int streak = 0;  // consecutive data grants taken while a fetch was waiting

  always #5 clk = ~clk;

  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata), .busy(busy), .protocol_err(protocol_err)
  );

  // Requesters must hold req until their addr_ok.
  logic inst_wait_q = 1'b0, data_wait_q = 1'b0;
  always @(posedge clk) begin
    if (resetn) begin
      assert (!(inst_wait_q && !inst_req)) else $error("inst_req dropped before inst_addr_ok");
      assert (!(data_wait_q && !data_req)) else $error("data_req dropped before data_addr_ok");
    end
    inst_wait_q <= resetn && inst_req && !inst_addr_ok;
    data_wait_q <= resetn && data_req && !data_addr_ok;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
  endtask

  // Reference arbitration rule: returns 1 when data should win this grant.
  task automatic model_pick(input bit i, input bit d, output bit pick_d);
    pick_d = d && !(i && streak == LIM);
    if (pick_d && i) streak = (streak < LIM) ? streak + 1 : LIM;
    else streak = 0;
  endtask

  task automatic new_inst_req();
    inst_addr = $urandom; inst_size = 2'($urandom_range(0, 2));
    inst_wdata = $urandom; inst_wr = 1'b0;
  endtask

  task automatic new_data_req();
    data_addr = $urandom; data_size = 2'($urandom_range(0, 2));
    data_wdata = $urandom; data_wr = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    resetn = 0;
    clear_inputs();
    mem_data_ok = 1; mem_rdata = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (all_out !== '0) $display("FAIL reset_outputs: got %h expected 0", all_out); else passed++;
    tick();
    resetn = 1; mem_data_ok = 0; mem_rdata = 0;
    streak = 0;
    @(negedge clk);
    checks++;
    if (all_out !== '0) $display("FAIL post_reset_idle: got %h expected 0", all_out); else passed++;
    tick();
  endtask

  task automatic test_single_fetch();
    bit d;
    inst_req = 1; inst_wr = 0; inst_size = SZ_WORD; inst_addr = 32'hBFC0_0000; inst_wdata = 0;
    model_pick(1, 0, d);
    @(negedge clk);
    checks++;
    if ({busy, mem_req} !== 2'b00) $display("FAIL fetch_idle: got %b expected 00", {busy, mem_req}); else passed++;
    tick();
    mem_addr_ok = 1;
    @(negedge clk);
    checks++;
    if ({mem_req, mem_wr, mem_size, mem_addr, inst_addr_ok, data_addr_ok} !== {1'b1, 1'b0, SZ_WORD, 32'hBFC0_0000, 2'b10})
      $display("FAIL fetch_req: got %h expected %h", {mem_req, mem_wr, mem_size, mem_addr, inst_addr_ok, data_addr_ok},
               {1'b1, 1'b0, SZ_WORD, 32'hBFC0_0000, 2'b10});
    else passed++;
    tick();
    inst_req = 0; mem_addr_ok = 0;
    @(negedge clk);
    checks++;
    if ({mem_req, busy, inst_data_ok, data_data_ok} !== 4'b0100)
      $display("FAIL fetch_wait: got %b expected 0100", {mem_req, busy, inst_data_ok, data_data_ok});
    else passed++;
    tick();
    mem_data_ok = 1; mem_rdata = 32'h3C1D_0000;
    @(negedge clk);
    checks++;
    if ({inst_data_ok, inst_rdata, data_data_ok, data_rdata} !== {1'b1, 32'h3C1D_0000, 1'b0, 32'h0})
      $display("FAIL fetch_resp: got %h expected %h", {inst_data_ok, inst_rdata, data_data_ok, data_rdata},
               {1'b1, 32'h3C1D_0000, 1'b0, 32'h0});
    else passed++;
    tick();
    mem_data_ok = 0; mem_rdata = 0;
    @(negedge clk);
    checks++;
    if (all_out !== '0) $display("FAIL fetch_done: got %h expected 0", all_out); else passed++;
    $display("single fetch done");
    tick();
  endtask

  task automatic test_store();
    bit d;
    data_req = 1; data_wr = 1; data_size = SZ_WORD; data_addr = 32'h8000_1000; data_wdata = 32'hDEAD_BEEF;
    model_pick(0, 1, d);
    tick();
    mem_addr_ok = 1;
    @(negedge clk);
    checks++;
    if ({mem_req, mem_wr, mem_size, mem_addr, mem_wdata, inst_addr_ok, data_addr_ok} !==
        {1'b1, 1'b1, SZ_WORD, 32'h8000_1000, 32'hDEAD_BEEF, 2'b01})
      $display("FAIL store_req: got %h expected %h",
               {mem_req, mem_wr, mem_size, mem_addr, mem_wdata, inst_addr_ok, data_addr_ok},
               {1'b1, 1'b1, SZ_WORD, 32'h8000_1000, 32'hDEAD_BEEF, 2'b01});
    else passed++;
    tick();
    data_req = 0; data_wr = 0; mem_addr_ok = 0;
    mem_data_ok = 1; mem_rdata = 32'h0000_0007;
    @(negedge clk);
    checks++;
    if ({inst_data_ok, inst_rdata, data_data_ok, data_rdata} !== {1'b0, 32'h0, 1'b1, 32'h0000_0007})
      $display("FAIL store_ack: got %h expected %h", {inst_data_ok, inst_rdata, data_data_ok, data_rdata},
               {1'b0, 32'h0, 1'b1, 32'h0000_0007});
    else passed++;
    $display("store done");
    tick();
    mem_data_ok = 0; mem_rdata = 0;
  endtask

  task automatic test_stall();
    bit d;
    data_req = 1; data_wr = 0; data_size = SZ_HALF; data_addr = 32'h8000_2002; data_wdata = 0;
    model_pick(0, 1, d);
    tick();
    inst_req = 1; inst_wr = 0; inst_size = SZ_WORD; inst_addr = 32'hBFC0_0010; inst_wdata = 0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      checks++;
      if ({mem_req, mem_addr, inst_addr_ok, data_addr_ok} !== {1'b1, 32'h8000_2002, 2'b00})
        $display("FAIL stall_hold_%0d: got %h expected %h", s, {mem_req, mem_addr, inst_addr_ok, data_addr_ok},
                 {1'b1, 32'h8000_2002, 2'b00});
      else passed++;
      tick();
    end
    mem_addr_ok = 1;
    @(negedge clk);
    checks++;
    if ({mem_addr, inst_addr_ok, data_addr_ok} !== {32'h8000_2002, 2'b01})
      $display("FAIL stall_accept: got %h expected %h", {mem_addr, inst_addr_ok, data_addr_ok}, {32'h8000_2002, 2'b01});
    else passed++;
    tick();
    data_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h0000_BEEF;
    @(negedge clk);
    checks++;
    if ({inst_data_ok, data_data_ok, data_rdata} !== {2'b01, 32'h0000_BEEF})
      $display("FAIL stall_resp: got %h expected %h", {inst_data_ok, data_data_ok, data_rdata}, {2'b01, 32'h0000_BEEF});
    else passed++;
    tick();
    mem_data_ok = 0; mem_rdata = 0;
    model_pick(1, 0, d);
    tick();
    mem_addr_ok = 1;
    @(negedge clk);
    checks++;
    if ({mem_req, mem_addr, inst_addr_ok, data_addr_ok} !== {1'b1, 32'hBFC0_0010, 2'b10})
      $display("FAIL stall_fetch_next: got %h expected %h", {mem_req, mem_addr, inst_addr_ok, data_addr_ok},
               {1'b1, 32'hBFC0_0010, 2'b10});
    else passed++;
    tick();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h2408_0001;
    @(negedge clk);
    checks++;
    if ({inst_data_ok, inst_rdata, data_data_ok} !== {1'b1, 32'h2408_0001, 1'b0})
      $display("FAIL stall_fetch_resp: got %h expected %h", {inst_data_ok, inst_rdata, data_data_ok},
               {1'b1, 32'h2408_0001, 1'b0});
    else passed++;
    $display("stall scenario done");
    tick();
    mem_data_ok = 0; mem_rdata = 0;
  endtask

  task automatic test_spurious();
    bit d;
    mem_data_ok = 1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    checks++;
    if ({inst_data_ok, inst_rdata, data_data_ok, data_rdata, busy} !== '0)
      $display("FAIL spurious_idle_route: got %h expected 0", {inst_data_ok, inst_rdata, data_data_ok, data_rdata, busy});
    else passed++;
    tick();
    mem_data_ok = 0; mem_rdata = 0;
    @(negedge clk);
    checks++;
    if ({protocol_err, busy} !== 2'b10) $display("FAIL spurious_idle_err: got %b expected 10", {protocol_err, busy}); else passed++;
    tick();
    @(negedge clk);
    checks++;
    if (protocol_err !== 1'b0) $display("FAIL spurious_err_pulse: got %b expected 0", protocol_err); else passed++;
    // Spurious response while a request is still waiting for addr_ok.
    data_req = 1; data_wr = 0; data_size = SZ_BYTE; data_addr = 32'h1000_0040; data_wdata = 0;
    model_pick(0, 1, d);
    tick();
    tick();
    mem_data_ok = 1; mem_rdata = 32'hAAAA_5555;
    @(negedge clk);
    checks++;
    if ({inst_data_ok, data_data_ok, mem_req} !== 3'b001)
      $display("FAIL spurious_req_route: got %b expected 001", {inst_data_ok, data_data_ok, mem_req});
    else passed++;
    tick();
    mem_data_ok = 0; mem_rdata = 0;
    @(negedge clk);
    checks++;
    if ({protocol_err, mem_req, mem_addr} !== {2'b11, 32'h1000_0040})
      $display("FAIL spurious_req_err: got %h expected %h", {protocol_err, mem_req, mem_addr}, {2'b11, 32'h1000_0040});
    else passed++;
    tick();
    mem_addr_ok = 1;
    tick();
    mem_addr_ok = 0; data_req = 0; mem_data_ok = 1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    checks++;
    if ({data_data_ok, data_rdata, protocol_err} !== {1'b1, 32'h1234_5678, 1'b0})
      $display("FAIL spurious_recover: got %h expected %h", {data_data_ok, data_rdata, protocol_err},
               {1'b1, 32'h1234_5678, 1'b0});
    else passed++;
    $display("spurious response scenario done");
    tick();
    mem_data_ok = 0; mem_rdata = 0;
  endtask

  task automatic test_random();
    bit          ip, dp, exp_d;
    bit [5:0]    seq;
    int          stall, lat;
    logic [31:0] rd;
    logic [66:0] exp_mem;
    seq = 6'b101111;  // data,data,data,data,inst,data for k = 0..5
    ip = 0; dp = 0;
    for (int k = 0; k < 40 || ip || dp; k++) begin
      if (k < 40) begin
        if (!ip && (k < 6 || $urandom_range(0, 1) == 1)) begin ip = 1; new_inst_req(); end
        if (!dp && (k < 6 || $urandom_range(0, 1) == 1)) begin dp = 1; new_data_req(); end
        if (!ip && !dp) begin dp = 1; new_data_req(); end
      end
      inst_req = ip; data_req = dp;
      model_pick(ip, dp, exp_d);
      @(negedge clk);
      checks++;
      if ({busy, mem_req} !== 2'b00) $display("FAIL rand_idle_%0d: got %b expected 00", k, {busy, mem_req}); else passed++;
      tick();
      stall = (k < 6) ? 0 : $urandom_range(0, 2);
      for (int s = 0; s < stall; s++) begin
        if (exp_d && !ip && k < 40 && $urandom_range(0, 1) == 1) begin ip = 1; new_inst_req(); inst_req = 1; end
        if (!exp_d && !dp && k < 40 && $urandom_range(0, 1) == 1) begin dp = 1; new_data_req(); data_req = 1; end
        exp_mem = exp_d ? {data_wr, data_size, data_addr, data_wdata} : {inst_wr, inst_size, inst_addr, inst_wdata};
        @(negedge clk);
        checks++;
        if ({mem_req, mem_wr, mem_size, mem_addr, mem_wdata, inst_addr_ok, data_addr_ok} !== {1'b1, exp_mem, 2'b00})
          $display("FAIL rand_stall_%0d: got %h expected %h", k,
                   {mem_req, mem_wr, mem_size, mem_addr, mem_wdata, inst_addr_ok, data_addr_ok}, {1'b1, exp_mem, 2'b00});
        else passed++;
        tick();
      end
      mem_addr_ok = 1;
      exp_mem = exp_d ? {data_wr, data_size, data_addr, data_wdata} : {inst_wr, inst_size, inst_addr, inst_wdata};
      @(negedge clk);
      checks++;
      if ({mem_req, mem_wr, mem_size, mem_addr, mem_wdata, inst_addr_ok, data_addr_ok} !==
          {1'b1, exp_mem, (exp_d ? 2'b01 : 2'b10)})
        $display("FAIL rand_accept_%0d: got %h expected %h", k,
                 {mem_req, mem_wr, mem_size, mem_addr, mem_wdata, inst_addr_ok, data_addr_ok},
                 {1'b1, exp_mem, (exp_d ? 2'b01 : 2'b10)});
      else passed++;
      if (k < 6) begin
        checks++;
        if ({inst_addr_ok, data_addr_ok} !== (seq[k] ? 2'b01 : 2'b10))
          $display("FAIL starve_order_%0d: got %b expected %b", k, {inst_addr_ok, data_addr_ok}, (seq[k] ? 2'b01 : 2'b10));
        else passed++;
      end
      tick();
      mem_addr_ok = 0;
      if (exp_d) begin dp = 0; data_req = 0; end
      else begin ip = 0; inst_req = 0; end
      lat = (k < 6) ? 0 : $urandom_range(0, 2);
      for (int s = 0; s < lat; s++) begin
        @(negedge clk);
        checks++;
        if ({mem_req, busy, inst_data_ok, data_data_ok} !== 4'b0100)
          $display("FAIL rand_wait_%0d: got %b expected 0100", k, {mem_req, busy, inst_data_ok, data_data_ok});
        else passed++;
        tick();
      end
      rd = $urandom;
      mem_data_ok = 1; mem_rdata = rd;
      @(negedge clk);
      checks++;
      if ({inst_data_ok, inst_rdata, data_data_ok, data_rdata, protocol_err} !==
          (exp_d ? {1'b0, 32'h0, 1'b1, rd, 1'b0} : {1'b1, rd, 1'b0, 32'h0, 1'b0}))
        $display("FAIL rand_resp_%0d: got %h expected %h", k,
                 {inst_data_ok, inst_rdata, data_data_ok, data_rdata, protocol_err},
                 (exp_d ? {1'b0, 32'h0, 1'b1, rd, 1'b0} : {1'b1, rd, 1'b0, 32'h0, 1'b0}));
      else passed++;
      $display("txn %0d owner=%s stall=%0d lat=%0d rdata=%h streak=%0d", k, exp_d ? "DATA" : "INST",
               stall, lat, rd, streak);
      tick();
      mem_data_ok = 0; mem_rdata = 0;
    end
  endtask

  task automatic test_reset_mid();
    bit d;
    data_req = 1; data_wr = 0; data_size = SZ_WORD; data_addr = 32'h0000_2000; data_wdata = 0;
    model_pick(0, 1, d);
    tick();
    mem_addr_ok = 1;
    tick();
    mem_addr_ok = 0; data_req = 0;
    #2;
    resetn = 0;
    #1;
    checks++;
    if (all_out !== '0) $display("FAIL reset_async: got %h expected 0", all_out); else passed++;
    streak = 0;
    @(posedge clk);
    #1;
    resetn = 1;
    mem_data_ok = 1; mem_rdata = 32'h0000_0055;
    @(negedge clk);
    checks++;
    if ({inst_data_ok, data_data_ok, data_rdata, busy} !== '0)
      $display("FAIL late_resp_route: got %h expected 0", {inst_data_ok, data_data_ok, data_rdata, busy});
    else passed++;
    tick();
    mem_data_ok = 0; mem_rdata = 0;
    @(negedge clk);
    checks++;
    if ({protocol_err, busy, inst_data_ok, data_data_ok} !== 4'b1000)
      $display("FAIL late_resp_err: got %b expected 1000", {protocol_err, busy, inst_data_ok, data_data_ok});
    else passed++;
    $display("reset during response done");
    tick();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store();
    test_stall();
    test_spurious();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one sram-like memory port between the CPU instruction-fetch requester and the data requester.
- Sits between the core (pcF path and mem_enM path) and the single-port memory or bridge.
- Accepts one transaction at a time, routes the response back to its owner, and gives data priority with a starvation guard for fetch.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits; minimum 1

Ports:
clk  input  1  clock
resetn  input  1  reset, asynchronous, active-low
inst_req  input  1  fetch request; held stable until inst_addr_ok
inst_wr  input  1  write flag (0 for fetch)
inst_size  input  2  0=byte, 1=half, 2=word
inst_addr  input  ADDR_W  fetch address
inst_wdata  input  DATA_W  write data
inst_addr_ok  output  1  fetch request accepted
inst_data_ok  output  1  fetch response valid
inst_rdata  output  DATA_W  fetch read data
data_req  input  1  data request; held stable until data_addr_ok
data_wr  input  1  1 = store
data_size  input  2  as inst_size
data_addr  input  ADDR_W  data address
data_wdata  input  DATA_W  store data
data_addr_ok  output  1  data request accepted
data_data_ok  output  1  data response valid (load data or store ack)
data_rdata  output  DATA_W  load data
mem_req  output  1  request to memory
mem_wr  output  1  forwarded write flag
mem_size  output  2  forwarded size
mem_addr  output  ADDR_W  forwarded address
mem_wdata  output  DATA_W  forwarded write data
mem_addr_ok  input  1  memory accepted request
mem_data_ok  input  1  memory response valid; never in the same cycle as its own addr_ok
mem_rdata  input  DATA_W  memory read data
busy  output  1  state != IDLE
protocol_err  output  1  one-cycle pulse on an unexpected mem_data_ok

Behaviour:
- Clock and reset are fixed: clk, and resetn (asynchronous, active-low).
- Reset: state=IDLE, owner=INST, starve_cnt=0.
- All outputs are 0 during and after reset until a request arrives. rdata outputs are 0 whenever the matching data_ok is 0.
- FSM states are IDLE, REQ and RESP.
- IDLE:
  - No request: stay in IDLE.
  - One request: latch owner to that requester, go to REQ.
  - Both requesting: pick DATA unless starve_cnt == STARVE_LIMIT, in which case pick INST.
  - mem_req=0 in this state.
- REQ:
  - mem_req=1, and mem_wr/size/addr/wdata are driven combinationally from the owner's inputs.
  - mem_addr_ok is forwarded only to the owner's addr_ok in the same cycle.
  - On mem_addr_ok, go to RESP; otherwise stay, with owner locked (no re-arbitration mid-request).
- RESP:
  - mem_req=0.
  - On mem_data_ok, pulse the owner's data_ok for 1 cycle with rdata=mem_rdata, then go to IDLE.
- Latency:
  - Request cycle t gives mem_req at t+1 at the earliest.
  - mem_data_ok at cycle u gives owner data_ok at u (combinational pass-through).
  - Minimum round trip for back-to-back transactions is 3 cycles per transaction.
- Starvation counter:
  - Updated on the IDLE→REQ transition.
  - Grant DATA while inst_req=1: increment, saturating at STARVE_LIMIT.
  - Grant INST: clear to 0.
  - Grant DATA with inst_req=0: clear to 0.
- Non-owner addr_ok and data_ok stay 0 at all times.
- mem_data_ok in IDLE or REQ: ignored, protocol_err pulses, state unchanged.
- A requester dropping req in REQ before addr_ok is illegal. The arbiter still forwards the current (stale) signals; the bench flags it with an assertion.
- Reset asserted mid-transaction: immediate return to IDLE. An in-flight memory response arriving after reset release counts as an unexpected mem_data_ok (protocol_err pulse, otherwise ignored).

Decomposition:
- Shared package sram_arb_pkg holds:
  - state enum {IDLE, REQ, RESP}
  - owner encoding {OWN_INST=0, OWN_DATA=1}
  - size constants SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2
- Sub-module sram_arb_pick holds the priority decision plus starve_cnt register, with these ports:
  - inputs: clk, resetn, inst_req, data_req, grant_en
  - output: grant_owner

Test Plan:
- Single fetch: inst_req=1, addr=0xBFC00000; mem_addr_ok at t+1; mem_data_ok with 0x3C1D0000 at t+3 → inst_addr_ok pulse at t+1; inst_data_ok=1 with inst_rdata=0x3C1D0000 at t+3; data_* outputs stay 0.
- Simultaneous requests, memory always ready, STARVE_LIMIT=4 → grant order D,D,D,D,I,D… with starve_cnt sequence 1,2,3,4,0.
- Store routing: data_req=1, wr=1, size=2, addr=0x80001000, wdata=0xDEADBEEF → mem_* carry these values exactly; data_data_ok ack; inst_data_ok never asserted.
- Memory stalls addr_ok for 5 cycles while inst_req rises → mem_addr stays on data owner all 5 cycles; fetch served next.
- Spurious mem_data_ok in IDLE → protocol_err=1 for one cycle; no data_ok to either master; busy=0.
- resetn low during RESP → all outputs 0 asynchronously; after release a late mem_data_ok gives protocol_err and no data_ok.
